// File: rtl/mult_dot_accumulator_pkg.sv
// Shared types and constants for the product-stream dot-product accumulator.
// The product width matches the 16x16 multiplier that feeds this block.
package mult_dot_accumulator_pkg;

    localparam int MULT_PROD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/mult_acc_adder.sv
// Combinational ACC_W-bit adder of a running sum and a zero-extended product,
// with the carry-out exposed for the sticky overflow flag.
module mult_acc_adder #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] wide_sum;

    assign wide_sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
    assign sum      = wide_sum[ACC_W-1:0];
    assign carry    = wide_sum[ACC_W];

endmodule

// File: rtl/mult_dot_accumulator.sv
// Accumulates vec_len multiplier products into a wide sum and presents the
// result on a valid/ready output; overflow is the OR of all adder carry-outs.
module mult_dot_accumulator
    import mult_dot_accumulator_pkg::*;
#(
    parameter int PROD_W = MULT_PROD_W,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] product,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  result,
    output logic              overflow,
    output logic              busy
);

    acc_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W-1:0]  add_sum;
    logic              add_carry;

    mult_acc_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .acc     (acc_q),
        .product (product),
        .sum     (add_sum),
        .carry   (add_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            count_q  <= '0;
            len_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            len_q    <= len_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        len_d    = len_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    len_d   = vec_len;
                    if (vec_len == '0) begin
                        result_d = '0;
                        state_d  = HOLD;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                // prod_ready is high for the whole state, so prod_valid alone is the handshake
                if (prod_valid) begin
                    acc_d   = add_sum;
                    count_d = count_q + LEN_W'(1);
                    ovf_d   = ovf_q | add_carry;
                    if (count_q == len_q - LEN_W'(1)) begin
                        result_d = add_sum;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign prod_ready = (state_q == ACCUM);
    assign res_valid  = (state_q == HOLD);
    assign busy       = (state_q != IDLE);
    assign result     = result_q;
    assign overflow   = ovf_q;

endmodule

// File: doc/mult_dot_accumulator.md
Name: mult_dot_accumulator

Overview:
- Downstream stage of the 16x16 unsigned combinational multiplier; consumes its 32-bit product stream.
- Accumulates a programmed number of products into a wide sum (a dot product) and presents the result on a valid/ready output.
- Sits between the multiplier's registered output and the result consumer (bus register or next arithmetic stage).

Parameters:
- PROD_W, 32, width of the incoming unsigned product.
- ACC_W, 40, accumulator/result width; must be >= PROD_W.
- LEN_W, 8, width of the vector-length field; maximum length is 2^LEN_W-1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse that begins a new accumulation; honoured only in IDLE.
- vec_len  in  LEN_W  number of products to accumulate; sampled when start is honoured.
- prod_valid  in  1  product input valid.
- prod_ready  out  1  block accepts a product this cycle.
- product  in  PROD_W  unsigned product from the multiplier.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- result  out  ACC_W  accumulated sum, registered.
- overflow  out  1  sticky; set if any addition carried out of ACC_W during this accumulation.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; accumulator, result, count and latched length cleared; prod_ready=0, res_valid=0, overflow=0, busy=0. Reset mid-operation discards partial sums; no result is emitted.
- States: IDLE, ACCUM, HOLD.
- IDLE: prod_ready=0. On start=1:
  - clear accumulator, count and overflow;
  - latch vec_len;
  - if vec_len==0, go to HOLD with result=0;
  - otherwise go to ACCUM.
- ACCUM: prod_ready=1, combinational from state only, with no dependency on prod_valid.
  - Handshake is prod_valid && prod_ready. On each handshake, acc <= acc + zero-extended product and count <= count+1.
  - Cycles with prod_valid=0 change nothing.
  - On the handshake where count==len-1: register the final sum into result, capture the carry-out into overflow, and go to HOLD.
- HOLD: res_valid=1 and prod_ready=0.
  - result and overflow stay stable while res_valid=1 && res_ready=0.
  - On res_ready=1, go to IDLE next cycle with res_valid=0.
  - result and overflow keep their values after leaving HOLD until the next start.
- Latency: res_valid rises on the clock edge of the last product handshake, i.e. it is visible the cycle after that handshake. With vec_len==0, res_valid is visible the cycle after start.
- Throughput: one product per cycle in ACCUM. At least 2 cycles pass between results (HOLD, then IDLE).
- start outside IDLE is ignored, with no effect on length, accumulator or state.
- Arithmetic: unsigned, modulo 2^ACC_W. The overflow bit is the OR of the carry-outs of all additions since start.
- Simultaneous start and res_ready in HOLD: res_ready is honoured and start is ignored. A new start is honoured in IDLE only.
- Count wrap is impossible: count never exceeds len-1 because the FSM leaves ACCUM on the last handshake.

Decomposition:
- Shared package:
  - state encoding enum: IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2;
  - PROD_W default constant, shared with the multiplier's product width.
- Natural sub-module: mult_acc_adder. It is a combinational ACC_W adder with zero-extension of the product and a carry-out. It keeps the overflow logic isolated and reusable.
- FSM, counter and output registers stay in the top module.

Test Plan:
- vec_len=3, products 0xFFFE0001 x3 back-to-back, res_ready=1 -> result=0x2FFFA0003, overflow=0, res_valid high for exactly 1 cycle, starting 1 cycle after the 3rd handshake.
- ACC_W=33 instance, same 3 products -> result=0x0FFFA0003, overflow=1. With only 2 products -> result=0x1FFFC0002, overflow=0.
- vec_len=0 start -> prod_ready never asserts; res_valid=1 the next cycle with result=0, overflow=0.
- vec_len=4, prod_valid toggled 1,0,0,1,1,0,1 with products 1,2,3,4 -> exactly 4 handshakes, result=10; prod_ready=1 throughout ACCUM.
- Result backpressure: res_ready=0 for 5 cycles while start pulses -> result stable, state stays HOLD, start ignored; after res_ready=1, IDLE and a new start is accepted.
- rst_n=0 after 2 of 5 products -> next cycle busy=0, prod_ready=0, result=0, res_valid=0. A subsequent vec_len=1 run with product 7 gives result=7.
